// File: rtl/guia_pkg.sv
// Shared definitions for the gate-exercise response checker: checker states and
// reference truth tables for the two-input exercise gates.
package guia_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Bit i is the expected gate output for input vector i.
  localparam logic [3:0] TtAnd  = 4'b1000;
  localparam logic [3:0] TtOr   = 4'b1110;
  localparam logic [3:0] TtNand = 4'b0111;
  localparam logic [3:0] TtNor  = 4'b0001;
  localparam logic [3:0] TtXor  = 4'b0110;

endpackage

// File: rtl/tt_lookup.sv
// Expected-output lookup: selects the truth-table row addressed by the input vector.
module tt_lookup #(
  parameter int unsigned        N     = 2,
  parameter logic [(1<<N)-1:0]  TRUTH = guia_pkg::TtAnd
) (
  input  logic [N-1:0] in_vec,
  output logic         expected
);

  assign expected = TRUTH[in_vec];

endmodule

// File: rtl/truth_table_checker.sv
// Grades a gate by comparing driven vector/response pairs against a truth table.
// Optional first-failure capture ports are enabled with TTC_FIRST_FAIL_CAPTURE_EN.
module truth_table_checker
  import guia_pkg::*;
#(
  parameter int unsigned        N     = 2,
  parameter logic [(1<<N)-1:0]  TRUTH = guia_pkg::TtAnd,
  parameter int unsigned        CW    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_vec,
  input  logic              in_s,
  output logic [CW-1:0]     vec_count,
  output logic [CW-1:0]     err_count,
  output logic [(1<<N)-1:0] coverage,
  output logic              done,
  output logic              pass
`ifdef TTC_FIRST_FAIL_CAPTURE_EN
  ,
  output logic              fail_valid,
  output logic [N-1:0]      fail_vec,
  output logic              fail_s
`endif
);

  localparam int unsigned Rows = 1 << N;

  state_e            state_q, state_d;
  logic [CW-1:0]     vec_q, vec_d;
  logic [CW-1:0]     err_q, err_d;
  logic [Rows-1:0]   cov_q, cov_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              expected;
  logic              mismatch;
  logic              clr;
  logic              acc;

  tt_lookup #(
    .N     (N),
    .TRUTH (TRUTH)
  ) u_lookup (
    .in_vec   (in_vec),
    .expected (expected)
  );

  assign mismatch = (in_s != expected);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    cov_d   = cov_q;
    done_d  = done_q;
    pass_d  = pass_q;
    clr     = 1'b0;
    acc     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCheck;
          clr     = 1'b1;
        end
      end
      StCheck: begin
        // A transfer coinciding with start becomes the first pair of the new run.
        clr = start;
        acc = in_valid;
      end
      StDone: begin
        if (start) begin
          state_d = StCheck;
          clr     = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      vec_d = '0;
      err_d = '0;
      cov_d = '0;
    end

    if (acc) begin
      if (vec_d != {CW{1'b1}}) vec_d = vec_d + CW'(1);
      if (mismatch && (err_d != {CW{1'b1}})) err_d = err_d + CW'(1);
      cov_d[in_vec] = 1'b1;
    end

    if ((state_q == StCheck) && (&cov_d)) begin
      state_d = StDone;
      done_d  = 1'b1;
      pass_d  = (err_d == '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      vec_q   <= '0;
      err_q   <= '0;
      cov_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign in_ready  = (state_q == StCheck);
  assign vec_count = vec_q;
  assign err_count = err_q;
  assign coverage  = cov_q;
  assign done      = done_q;
  assign pass      = pass_q;

`ifdef TTC_FIRST_FAIL_CAPTURE_EN
  logic         fv_q, fv_d;
  logic [N-1:0] fvec_q, fvec_d;
  logic         fs_q, fs_d;

  always_comb begin
    fv_d   = fv_q;
    fvec_d = fvec_q;
    fs_d   = fs_q;
    if (clr) begin
      fv_d   = 1'b0;
      fvec_d = '0;
      fs_d   = 1'b0;
    end
    if (acc && mismatch && !fv_d) begin
      fv_d   = 1'b1;
      fvec_d = in_vec;
      fs_d   = in_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fv_q   <= 1'b0;
      fvec_q <= '0;
      fs_q   <= 1'b0;
    end else begin
      fv_q   <= fv_d;
      fvec_q <= fvec_d;
      fs_q   <= fs_d;
    end
  end

  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;
  assign fail_s     = fs_q;
`endif

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Sequential response checker for the gate exercises. It is the receiving end of the stimulus/response pattern the gate testbenches use. A driver presents each input vector together with the DUT output it produced. This block compares that output against a parameterised expected truth table, counts mismatches, and tracks which input combinations have been exercised. It reports done/pass once every combination has been seen, so a gate module such as a NOR-built AND is graded in hardware rather than by reading `$monitor` output.

## Interface
Parameters:
- `N`, 2, input vector width; truth table has 2^N rows.
- `TRUTH`, 4'b1000, expected output per row, bit i = expected `s` for `in_vec == i`. The default is AND.
- `CW`, 8, width of the vector and error counters.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clock`  in  1  rising-edge clock.
  - `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  begin or restart a run; clears counters and coverage.
- `in_valid`  in  1  driver has a vector/response pair.
- `in_ready`  out  1  checker accepts a pair this cycle.
- `in_vec`  in  N  input vector applied to the DUT.
- `in_s`  in  1  DUT output for `in_vec`.
- `vec_count`  out  CW  pairs accepted this run, saturating.
- `err_count`  out  CW  mismatches this run, saturating.
- `coverage`  out  2^N  bit i set once row i has been seen.
- `done`  out  1  all rows covered; run complete.
- `pass`  out  1  `done` and `err_count == 0`.

## Operation
- FSM states and transitions:
  - IDLE to CHECK on `start`.
  - CHECK to DONE on the transfer that sets the last `coverage` bit.
  - DONE to CHECK on `start`.
  - `start` in CHECK restarts the run and stays in CHECK.
- Transfer occurs when `in_valid && in_ready`. `in_ready = (state == CHECK)`, decoded from the state register only.
- On each transfer:
  - `vec_count` increments.
  - `coverage[in_vec]` is set.
  - If `in_s != TRUTH[in_vec]`, `err_count` increments.
- Both counters saturate at 2^CW-1 and never wrap.
- Repeated vectors are checked and counted each time; coverage is idempotent.
- `start` clears `vec_count`, `err_count` and `coverage`.
  - If `start` coincides with a transfer in CHECK, that transfer is the first pair of the new run: counters become 1 or 0 accordingly, and `coverage` becomes one-hot.
- `in_valid` outside CHECK is ignored. Nothing is counted.

## Timing
- Reset values: state IDLE, `in_ready` 0, `vec_count` 0, `err_count` 0, `coverage` 0, `done` 0, `pass` 0.
- All outputs are registered. Counters and coverage reflect a transfer one cycle after the accepting edge.
- Completion:
  - The edge that accepts the completing pair also moves state to DONE.
  - `done`, `pass` and the final counts are valid in the following cycle.
  - `in_ready` is 0 from that cycle on.
- `done` and `pass` hold in DONE until `start` or `reset`. On `start` they drop at the next edge.
- `reset` asserted mid-run forces the reset values immediately (asynchronous) and discards the partial run.
- Throughput: one pair per cycle in CHECK; no bubbles.

## Configuration
- `TTC_FIRST_FAIL_CAPTURE_EN` defined:
  - Adds outputs `fail_valid` (1), `fail_vec` (N) and `fail_s` (1).
  - These capture the first mismatching pair of the run. Later mismatches do not overwrite them.
  - They are cleared by `reset` and `start`. They update one cycle after the failing transfer.
- Macro undefined: these ports and registers do not exist. All other behaviour is identical.

## Structure
- Shared package `guia_pkg`:
  - State encodings: IDLE=2'd0, CHECK=2'd1, DONE=2'd2.
  - Default truth-table constants for the exercise gates: AND 4'b1000, OR 4'b1110, NAND 4'b0111, NOR 4'b0001, XOR 4'b0110.
- Sub-module `tt_lookup`: combinational mux, `expected = TRUTH[in_vec]`, parameterised on `N`. The checker instantiates it once.

## Test plan
- Default AND table:
  - Stimulus: `start`, then 00/0, 01/0, 10/0, 11/1 on consecutive cycles.
  - Response: `done` = 1, `pass` = 1, `err_count` = 0, `vec_count` = 4, `coverage` = 4'b1111, `in_ready` = 0 afterwards.
- Single mismatch:
  - Stimulus: same sequence with 11/0.
  - Response: `err_count` = 1, `pass` = 0, `done` = 1.
  - With the macro defined: `fail_vec` = 2'b11, `fail_s` = 0.
- Repeats and idle input:
  - Stimulus: `in_valid` = 1 with 00/0 while in IDLE.
  - Response: `vec_count` stays 0.
  - Stimulus: then `start`, followed by 00/0 ×3, 01/0, 10/0, 11/1.
  - Response: `vec_count` = 6, `coverage` fills at the last pair, `pass` = 1.
- Restart and reset:
  - Stimulus: `start` in CHECK after two pairs, coinciding with a 10/1 transfer.
  - Response: `vec_count` = 1, `err_count` = 1, `coverage` = 4'b0100.
  - Stimulus: then `reset` asserted mid-cycle.
  - Response: all outputs 0 immediately.
- Saturation:
  - Stimulus: `CW` = 2, `start`, then 00/1 ×5 (all mismatches).
  - Response: `err_count` and `vec_count` hold at 3, `done` = 0.
